end_display_anim: RTL

END_DISPLAY_ANIM -- requirements
Module: end_display_anim

---
 rtl/end_display_pkg.sv | 48 ++++
 rtl/rect_hit.sv | 26 ++
 rtl/end_display_anim.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/end_display_pkg.sv
// Shared types and glyph geometry for the end-of-game display animation.
// Glyph rectangles are stored for the reference panel origin (380,220) and
// shifted by the instance's panel origin through shift_rect().
package end_display_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGrow = 2'd1,
        StShow = 2'd2
    } state_e;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] w;
        logic [11:0] h;
    } rect_t;

    localparam int RefPanelX = 380;
    localparam int RefPanelY = 220;

    localparam int unsigned NumLoseRects = 2;
    localparam int unsigned NumWinRects  = 4;

    // "L": vertical stroke plus foot.
    localparam rect_t LoseRects [NumLoseRects] = '{
        '{12'd440, 12'd270, 12'd20,  12'd100},
        '{12'd440, 12'd370, 12'd80,  12'd20}
    };

    // "W": two outer strokes, short middle stroke, shared base.
    localparam rect_t WinRects [NumWinRects] = '{
        '{12'd420, 12'd270, 12'd20,  12'd100},
        '{12'd470, 12'd325, 12'd20,  12'd50},
        '{12'd520, 12'd270, 12'd20,  12'd100},
        '{12'd420, 12'd370, 12'd120, 12'd20}
    };

    // Move a reference-origin rectangle to the actual panel origin.
    function automatic rect_t shift_rect(rect_t r, int dx, int dy);
        rect_t s;
        s   = r;
        s.x = 12'(int'(r.x) + dx);
        s.y = 12'(int'(r.y) + dy);
        return s;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test; left/top inclusive, right/bottom exclusive.
module rect_hit
    import end_display_pkg::*;
(
    input  logic [10:0] px_i,
    input  logic [9:0]  py_i,
    input  rect_t       rect_i,
    output logic        hit_o
);

    logic [12:0] x_end;
    logic [12:0] y_end;
    logic [12:0] px_ext;
    logic [12:0] py_ext;

    // Widen to 13 bits so x+w never wraps.
    always_comb begin
        px_ext = {2'b00, px_i};
        py_ext = {3'b000, py_i};
        x_end  = {1'b0, rect_i.x} + {1'b0, rect_i.w};
        y_end  = {1'b0, rect_i.y} + {1'b0, rect_i.h};
        hit_o  = (px_ext >= {1'b0, rect_i.x}) && (px_ext < x_end) &&
                 (py_ext >= {1'b0, rect_i.y}) && (py_ext < y_end);
    end

endmodule

// File: rtl/end_display_anim.sv
// End-of-game screen: a square panel grows from its centre, then shows a
// win (W) or lose (L) glyph. Output is registered, 2 cycles after hcount/vcount.
// Optional feature: define END_DISPLAY_BLINK_EN to blink the glyph in SHOW.
module end_display_anim
    import end_display_pkg::*;
#(
    parameter int          PANEL_X      = 380,
    parameter int          PANEL_Y      = 220,
    parameter int          PANEL_SIZE   = 200,
    parameter logic [23:0] PANEL_COLOR  = 24'hF4_63_05,
    parameter logic [23:0] GLYPH_COLOR  = 24'hFF_FF_FF,
    parameter int          GROW_STEP    = 10,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic        show_in,
    input  logic        win_in,
    output logic [23:0] color_out,
    output logic        active_out
);

    localparam logic [10:0] HalfMax  = 11'(PANEL_SIZE / 2);
    localparam logic [11:0] CenterX  = 12'(PANEL_X + PANEL_SIZE / 2);
    localparam logic [11:0] CenterY  = 12'(PANEL_Y + PANEL_SIZE / 2);
    localparam logic [11:0] GrowStep = 12'(GROW_STEP);
    localparam int          OffX     = PANEL_X - RefPanelX;
    localparam int          OffY     = PANEL_Y - RefPanelY;

    // Reject geometry that cannot be centred and blink phases that never end.
    if ((PANEL_SIZE % 2) != 0 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("end_display_anim: PANEL_SIZE must be even and BLINK_FRAMES >= 1");
    end

    state_e      state_d, state_q;
    logic [10:0] half_d, half_q;
    logic        win_d, win_q;
    logic [11:0] grow_sum;
    logic        glyph_vis;

    // Next-state: show_in low always wins and clears the animation.
    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        win_d    = win_q;
        grow_sum = {1'b0, half_q} + GrowStep;
        if (!show_in) begin
            state_d = StIdle;
            half_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StGrow;
                    win_d   = win_in;
                    half_d  = '0;
                end
                StGrow: begin
                    if (new_frame_in) begin
                        if (grow_sum >= {1'b0, HalfMax}) begin
                            half_d  = HalfMax;
                            state_d = StShow;
                        end else begin
                            half_d = grow_sum[10:0];
                        end
                    end
                end
                StShow: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Animation state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            half_q  <= '0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            win_q   <= win_d;
        end
    end

`ifdef END_DISPLAY_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

    logic [BlinkW-1:0] blink_cnt_d, blink_cnt_q;
    logic              blink_vis_d, blink_vis_q;

    // Held cleared/visible outside SHOW so every SHOW entry starts visible.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        if (state_d != StShow) begin
            blink_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (state_q == StShow && new_frame_in) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            blink_cnt_q <= '0;
            blink_vis_q <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_vis_q <= blink_vis_d;
        end
    end

    assign glyph_vis = blink_vis_q;
`else
    assign glyph_vis = 1'b1;
`endif

    rect_t                   panel_rect;
    logic                    panel_hit;
    logic [NumLoseRects-1:0] lose_hit;
    logic [NumWinRects-1:0]  win_hit;

    // Panel square around the fixed centre; zero half-size gives an empty square.
    always_comb begin
        panel_rect.x = CenterX - {1'b0, half_q};
        panel_rect.y = CenterY - {1'b0, half_q};
        panel_rect.w = {half_q, 1'b0};
        panel_rect.h = {half_q, 1'b0};
    end

    rect_hit u_panel_hit (
        .px_i   (hcount_in),
        .py_i   (vcount_in),
        .rect_i (panel_rect),
        .hit_o  (panel_hit)
    );

    for (genvar i = 0; i < NumLoseRects; i++) begin : g_lose
        localparam rect_t Rect = shift_rect(LoseRects[i], OffX, OffY);
        rect_hit u_rect_hit (
            .px_i   (hcount_in),
            .py_i   (vcount_in),
            .rect_i (Rect),
            .hit_o  (lose_hit[i])
        );
    end

    for (genvar i = 0; i < NumWinRects; i++) begin : g_win
        localparam rect_t Rect = shift_rect(WinRects[i], OffX, OffY);
        rect_hit u_rect_hit (
            .px_i   (hcount_in),
            .py_i   (vcount_in),
            .rect_i (Rect),
            .hit_o  (win_hit[i])
        );
    end

    logic panel_hit_d, panel_hit_q;
    logic glyph_hit_d, glyph_hit_q;
    logic [23:0] color_d, color_q;
    logic        active_d, active_q;

    // Stage 1 qualifies raw hits with the registered state, so a new_frame
    // update only affects pixels sampled after it.
    always_comb begin
        panel_hit_d = (state_q != StIdle) && panel_hit;
        glyph_hit_d = (state_q == StShow) && glyph_vis &&
                      (win_q ? (|win_hit) : (|lose_hit));
    end

    // Stage 2 priority: glyph, then panel, then transparent.
    always_comb begin
        color_d  = '0;
        active_d = 1'b0;
        if (glyph_hit_q) begin
            color_d  = GLYPH_COLOR;
            active_d = 1'b1;
        end else if (panel_hit_q) begin
            color_d  = PANEL_COLOR;
            active_d = 1'b1;
        end
    end

    // Two-stage pixel pipeline.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            panel_hit_q <= 1'b0;
            glyph_hit_q <= 1'b0;
            color_q     <= '0;
            active_q    <= 1'b0;
        end else begin
            panel_hit_q <= panel_hit_d;
            glyph_hit_q <= glyph_hit_d;
            color_q     <= color_d;
            active_q    <= active_d;
        end
    end

    assign color_out  = color_q;
    assign active_out = active_q;

endmodule
